bitmask_lane_scheduler: RTL and testbench
=========================================

# bitmask_lane_scheduler

Multi-lane sequencer for bit-sparse (essential-bit) processing. It accepts one group of 7-bit magnitude bitmasks, one per lane. It then emits, one beat per cycle, the index of the lowest remaining set bit in every lane and clears that bit, until all lanes are exhausted. It sits between the weight/activation buffer and the bit-serial shift-and-add PE array, and drives the PE shift amounts under a valid/ready handshake.

## Interface
- `LANES`, default 8: number of independent bitmask lanes per group (1..32).
- `clk` input, 1: clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `in_val` input, 1: a new mask group is presented.
- `in_rdy` output, 1: the scheduler can accept a group this cycle.
- `in_mask` input, LANES*7: lane i mask at bits [7i+6:7i].
- `out_val` output, 1: a beat is presented.
- `out_rdy` input, 1: downstream accepts the beat.
- `out_idx` output, LANES*3: lane i bit index at [3i+2:3i], range 0..6.
- `out_lane_val` output, LANES: lane i has a set bit in this beat.
- `out_beat` output, 3: beat number within the group, 0-based.
- `out_last` output, 1: this is the final beat of the group.
- `busy` output, 1: a group is held in the scheduler.

## Operation
- **States:** IDLE and RUN.
- **IDLE:**
  - `in_rdy`=1. On `in_val && in_rdy`, register `in_mask` into per-lane remaining-mask registers and clear the beat counter.
  - Go to RUN. Exception: under skip-zero (see Configuration), an all-zero group stays in IDLE.
- **RUN:**
  - `out_val`=1.
  - Per lane, `out_idx` is the index of the lowest set remaining bit. Lowest index has priority: mask 7'b1010100 gives idx 2.
  - `out_lane_val[i]` = |mask_i.
  - Lanes with an empty mask drive `out_idx`=0 and `out_lane_val`=0.
- **Fire (`out_val && out_rdy`):**
  - Every lane with `out_lane_val`=1 clears its lowest set bit (mask & (mask-1)).
  - `out_beat` increments.
- **`out_last`:** 1 when every lane's mask has at most one bit set, i.e. after this fire all masks are zero.
  - On a fire with `out_last`, return to IDLE, unless a new group is accepted in the same cycle. In that case, load it and stay in RUN.
- **`in_rdy` in RUN:** `out_val && out_rdy && out_last`. This is a back-to-back handoff with no bubble, and the only combinational in→out path.
- **Beats per group:** max popcount over lanes, minimum 1. `out_beat` never exceeds 6.
- **All-zero group without skip-zero:** exactly one beat, `out_lane_val`=0, `out_last`=1, `out_beat`=0.
- **Stall:** while `out_rdy`=0 in RUN, all outputs and registers hold steady.
- **`busy`:** equals (state==RUN).

## Timing
- **During reset:**
  - Registers: state=IDLE, masks=0, beat=0.
  - Outputs: `out_val`=0, `in_rdy`=0, `out_lane_val`=0, `out_idx`=0, `out_beat`=0, `out_last`=0, `busy`=0.
- **First cycle after reset:** `in_rdy`=1.
- **Latency:** a group accepted at edge t presents beat 0 in the cycle after t. One beat per cycle at full throughput.
- **Reset mid-group:** the group is discarded. IDLE is reached on the next edge, and no further beats are emitted.
- `out_*` come from registers through the lowest-set-bit encoders. The only combinational input dependency is `in_rdy` on `out_rdy`.

## Configuration
- **`BITSIM_SCHED_SKIP_ZERO_EN`**
  - **Defined:** an all-zero group is accepted in IDLE (`in_rdy`=1) and dropped with no output beat. State stays IDLE. In the RUN last-beat handoff, an all-zero incoming group also returns to IDLE.
  - **Undefined:** an all-zero group produces one empty beat with `out_last`=1, so downstream sees exactly one beat sequence per group.

## Test plan
- **Basic sequencing.** LANES=2, lane0=7'b1010100, lane1=7'b0000001, `out_rdy`=1.
  - Beat0: idx {0,2}, lane_val 2'b11.
  - Beat1: idx {0,4}, lane_val 2'b01.
  - Beat2: idx {0,6}, lane_val 2'b01, `out_last`=1.
  - `out_beat` runs 0,1,2.
- **Backpressure.** Same group, `out_rdy` low for 3 cycles at beat1 → beat1 values held unchanged; beat2 follows the first ready cycle. Total 3 fires.
- **Back-to-back.** Group A = all lanes 7'b0000010, group B offered immediately → B accepted on A's last fire. B beat0 in the next cycle, no idle bubble; `busy` stays 1.
- **All-zero group.**
  - Without macro: one beat, lane_val 0, `out_last`=1.
  - With `BITSIM_SCHED_SKIP_ZERO_EN`: no `out_val`, `in_rdy` stays 1.
- **Full mask.** Lane = 7'b1111111 → 7 beats, idx 0..6, `out_beat` 0..6, `out_last` only on beat 6.
- **Reset mid-group.** Assert `reset` at beat1 of a 3-beat group → `out_val`=0 during reset; IDLE with `in_rdy`=1 after. A new group starts at beat 0.

Source files
------------

// File: rtl/bitmask_lane_scheduler.sv
// Essential-bit lane sequencer: emits the lowest remaining set bit of every lane per beat.
// Optional macro BITSIM_SCHED_SKIP_ZERO_EN drops all-zero groups without emitting a beat.
module bitmask_lane_scheduler #(
  parameter int LANES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [LANES*7-1:0]   in_mask,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [LANES*3-1:0]   out_idx,
  output logic [LANES-1:0]     out_lane_val,
  output logic [2:0]           out_beat,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

`ifdef BITSIM_SCHED_SKIP_ZERO_EN
  localparam logic SKIP_ZERO = 1'b1;
`else
  localparam logic SKIP_ZERO = 1'b0;
`endif

  state_t     state_r, state_s;
  logic [6:0] mask_r [LANES];
  logic [6:0] mask_s [LANES];
  logic [2:0] beat_r, beat_s;
  logic       run_s, fire_s, accept_s, last_s, in_zero_s;

  // Lowest set bit wins; an empty mask encodes to 0.
  function automatic logic [2:0] lsb_idx(input logic [6:0] m);
    casez (m)
      7'b??????1: lsb_idx = 3'd0;
      7'b?????10: lsb_idx = 3'd1;
      7'b????100: lsb_idx = 3'd2;
      7'b???1000: lsb_idx = 3'd3;
      7'b??10000: lsb_idx = 3'd4;
      7'b?100000: lsb_idx = 3'd5;
      7'b1000000: lsb_idx = 3'd6;
      default:    lsb_idx = 3'd0;
    endcase
  endfunction

  function automatic logic at_most_one(input logic [6:0] m);
    at_most_one = ((m & (m - 7'd1)) == 7'd0);
  endfunction

  assign run_s     = (state_r == RUN) && !reset;
  assign fire_s    = run_s && out_rdy;
  assign in_rdy    = !reset && ((state_r == IDLE) || (fire_s && last_s));
  assign accept_s  = in_val && in_rdy;
  assign in_zero_s = (in_mask == {(LANES*7){1'b0}});
  assign out_val   = run_s;
  assign busy      = run_s;
  assign out_last  = run_s && last_s;
  assign out_beat  = run_s ? beat_r : 3'd0;

  // Per-lane lowest-set-bit encoders and last-beat detection
  always_comb begin
    out_idx      = {(LANES*3){1'b0}};
    out_lane_val = {LANES{1'b0}};
    last_s       = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (run_s) begin
        out_idx[3*i +: 3] = lsb_idx(mask_r[i]);
        out_lane_val[i]   = |mask_r[i];
      end else begin
        out_idx[3*i +: 3] = 3'd0;
        out_lane_val[i]   = 1'b0;
      end
      last_s = last_s & at_most_one(mask_r[i]);
    end
  end

  // Next-state, mask and beat-counter logic
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    for (int i = 0; i < LANES; i++) mask_s[i] = mask_r[i];
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          for (int i = 0; i < LANES; i++) mask_s[i] = in_mask[7*i +: 7];
          beat_s  = 3'd0;
          state_s = (SKIP_ZERO && in_zero_s) ? IDLE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (fire_s) begin
          if (accept_s) begin
            // Back-to-back handoff on the last beat: load without a bubble
            for (int i = 0; i < LANES; i++) mask_s[i] = in_mask[7*i +: 7];
            beat_s  = 3'd0;
            state_s = (SKIP_ZERO && in_zero_s) ? IDLE : RUN;
          end else if (last_s) begin
            for (int i = 0; i < LANES; i++) mask_s[i] = 7'd0;
            beat_s  = 3'd0;
            state_s = IDLE;
          end else begin
            for (int i = 0; i < LANES; i++) mask_s[i] = mask_r[i] & (mask_r[i] - 7'd1);
            beat_s  = beat_r + 3'd1;
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, mask and beat registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      beat_r  <= 3'd0;
      for (int i = 0; i < LANES; i++) mask_r[i] <= 7'd0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      for (int i = 0; i < LANES; i++) mask_r[i] <= mask_s[i];
    end
  end

endmodule

// File: tb/tb_bitmask_lane_scheduler.sv
// Directed table-driven bench for bitmask_lane_scheduler (LANES=2) plus hand-written
// full-mask and reset-mid-group sequences.
module tb_bitmask_lane_scheduler;

  localparam int LANES = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_val;
  logic              in_rdy;
  logic [LANES*7-1:0] in_mask;
  logic              out_val;
  logic              out_rdy;
  logic [LANES*3-1:0] out_idx;
  logic [LANES-1:0]  out_lane_val;
  logic [2:0]        out_beat;
  logic              out_last;
  logic              busy;

  int checks = 0;
  int errors = 0;

  bitmask_lane_scheduler #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_mask(in_mask),
    .out_val(out_val), .out_rdy(out_rdy), .out_idx(out_idx), .out_lane_val(out_lane_val),
    .out_beat(out_beat), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [13:0] im;
    logic        ordy;
    logic        e_oval;
    logic        e_irdy;
    logic [5:0]  e_idx;
    logic [1:0]  e_lv;
    logic [2:0]  e_beat;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  localparam logic [13:0] G  = {7'b0000001, 7'b1010100};
  localparam logic [13:0] A  = {7'b0000010, 7'b0000010};
  localparam logic [13:0] Z  = 14'd0;
  localparam logic [13:0] FM = {7'b0000000, 7'b1111111};

  function automatic vec_t mk(input logic rst, input logic iv, input logic [13:0] im,
                              input logic ordy, input logic oval, input logic irdy,
                              input logic [5:0] idx, input logic [1:0] lv,
                              input logic [2:0] beat, input logic last, input logic bsy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.im = im; v.ordy = ordy;
    v.e_oval = oval; v.e_irdy = irdy; v.e_idx = idx; v.e_lv = lv;
    v.e_beat = beat; v.e_last = last; v.e_busy = bsy;
    return v;
  endfunction

  function automatic vec_t idle_row(input logic iv, input logic [13:0] im);
    return mk(1'b0, iv, im, 1'b1, 1'b0, 1'b1, 6'd0, 2'b00, 3'd0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [13:0] im, input logic ordy);
    reset = rst; in_val = iv; in_mask = im; out_rdy = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] pack_out();
    return {out_val, in_rdy, out_idx, out_lane_val, out_beat, out_last, busy};
  endfunction

  initial begin
    drive(1'b1, 1'b0, Z, 1'b1);

    // Reset: everything quiet, even with a group offered
    tbl.push_back(mk(1'b1, 1'b0, Z, 1'b1, 1'b0, 1'b0, 6'd0, 2'b00, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, G, 1'b1, 1'b0, 1'b0, 6'd0, 2'b00, 3'd0, 1'b0, 1'b0));
    tbl.push_back(idle_row(1'b0, Z));
    // Basic sequencing
    tbl.push_back(idle_row(1'b1, G));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b0, 6'o02, 2'b11, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b0, 6'o04, 2'b01, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b1, 6'o06, 2'b01, 3'd2, 1'b1, 1'b1));
    tbl.push_back(idle_row(1'b0, Z));
    // Backpressure at beat1 for three cycles
    tbl.push_back(idle_row(1'b1, G));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b0, 6'o02, 2'b11, 3'd0, 1'b0, 1'b1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 6'o04, 2'b01, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b0, 6'o04, 2'b01, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 6'o06, 2'b01, 3'd2, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b1, 6'o06, 2'b01, 3'd2, 1'b1, 1'b1));
    tbl.push_back(idle_row(1'b0, Z));
    // Back-to-back: A (one beat) hands off to G with no bubble
    tbl.push_back(idle_row(1'b1, A));
    tbl.push_back(mk(1'b0, 1'b1, G, 1'b1, 1'b1, 1'b1, 6'o11, 2'b11, 3'd0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b0, 6'o02, 2'b11, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b0, 6'o04, 2'b01, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b1, 6'o06, 2'b01, 3'd2, 1'b1, 1'b1));
    tbl.push_back(idle_row(1'b0, Z));
    // All-zero group
    tbl.push_back(idle_row(1'b1, Z));
`ifdef BITSIM_SCHED_SKIP_ZERO_EN
    tbl.push_back(idle_row(1'b0, Z));
`else
    tbl.push_back(mk(1'b0, 1'b0, Z, 1'b1, 1'b1, 1'b1, 6'd0, 2'b00, 3'd0, 1'b1, 1'b1));
`endif
    tbl.push_back(idle_row(1'b0, Z));

    for (int r = 0; r < tbl.size(); r++) begin
      logic [14:0] exp_v;
      drive(tbl[r].rst, tbl[r].iv, tbl[r].im, tbl[r].ordy);
      exp_v = {tbl[r].e_oval, tbl[r].e_irdy, tbl[r].e_idx, tbl[r].e_lv,
               tbl[r].e_beat, tbl[r].e_last, tbl[r].e_busy};
      @(negedge clk);
      check($sformatf("row%0d", r), {17'd0, pack_out()}, {17'd0, exp_v});
      next_cycle();
    end

    // Full mask: seven beats, idx 0..6, last only on beat 6
    drive(1'b0, 1'b1, FM, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, Z, 1'b1);
    for (int k = 0; k < 7; k++) begin
      logic [14:0] exp_v;
      logic [2:0]  kk;
      kk = k[2:0];
      exp_v = {1'b1, (k == 6), 3'd0, kk, 2'b01, kk, (k == 6), 1'b1};
      @(negedge clk);
      check($sformatf("full_beat%0d", k), {17'd0, pack_out()}, {17'd0, exp_v});
      next_cycle();
    end
    @(negedge clk);
    check("full_idle", {31'd0, busy}, 32'd0);
    next_cycle();

    // Reset at beat1 of a three-beat group
    drive(1'b0, 1'b1, G, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, Z, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, Z, 1'b1);
    @(negedge clk);
    check("rst_mid_quiet", {17'd0, pack_out()}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, Z, 1'b1);
    @(negedge clk);
    check("rst_mid_idle", {17'd0, pack_out()}, {17'd0, 1'b0, 1'b1, 13'd0});
    next_cycle();
    drive(1'b0, 1'b1, G, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, Z, 1'b1);
    @(negedge clk);
    check("rst_restart_beat0", {17'd0, pack_out()},
          {17'd0, 1'b1, 1'b0, 6'o02, 2'b11, 3'd0, 1'b0, 1'b1});
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
